// File: rtl/bash_hash_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bash_hash_ctrl : word-serial load/unload and round sequencer for bash_hash.
// Optional abort_i port when BASH_HASH_CTRL_ABORT_EN is defined.   Rev 1.0
// ----------------------------------------------------------------------------
module bash_hash_ctrl #(
  parameter int SLEN   = 64,
  parameter int ROUNDS = 24
) (
  input  logic               clk_i,
  input  logic               rst_i,
`ifdef BASH_HASH_CTRL_ABORT_EN
  input  logic               abort_i,
`endif
  input  logic [1:0]         l_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [SLEN-1:0]    in_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [SLEN-1:0]    out_data_o,
  output logic               out_last_o,
  output logic               busy_o,
  output logic               prep_o,
  output logic               start_o,
  output logic               work_o,
  output logic [1:0]         l_o,
  output logic [16*SLEN-1:0] x_o,
  input  logic [8*SLEN-1:0]  y_i
);
  localparam int RW = $clog2(ROUNDS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_ROUND   = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_UNLOAD  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [3:0]      wcnt_q;
  logic [RW-1:0]   rcnt_q;
  logic [2:0]      ocnt_q;
  logic [1:0]      l_q;
  logic [SLEN-1:0] x_q [16];
  logic [SLEN-1:0] y_q [8];
  logic            abort, in_hs, out_hs, last_word;
  logic [2:0]      last_idx;
  logic [3:0]      wr_idx;

`ifdef BASH_HASH_CTRL_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  assign in_hs  = in_valid_i & in_ready_o & ~abort;
  assign out_hs = out_valid_o & out_ready_i;
  assign wr_idx = (state_q == S_IDLE) ? 4'd0 : wcnt_q;

  // Digest length follows the registered level: 4, 6 or 8 words.
  always_comb begin
    last_idx = 3'd7;
    case (l_q)
      2'b00:   last_idx = 3'd3;
      2'b01:   last_idx = 3'd5;
      default: last_idx = 3'd7;
    endcase
  end
  assign last_word = (ocnt_q == last_idx);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (in_hs) state_d = S_LOAD;
      S_LOAD:    if (in_hs && wcnt_q == 4'd15) state_d = S_START;
      S_START:   state_d = S_ROUND;
      S_ROUND:   if (rcnt_q == RW'(ROUNDS - 2)) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_UNLOAD;
      S_UNLOAD:  if (out_hs && last_word) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_comb begin
    in_ready_o  = ((state_q == S_IDLE) || (state_q == S_LOAD)) && !rst_i;
    start_o     = (state_q == S_START);
    prep_o      = (state_q == S_START);
    work_o      = (state_q == S_ROUND);
    out_valid_o = (state_q == S_UNLOAD);
    out_last_o  = (state_q == S_UNLOAD) && last_word;
    busy_o      = (state_q != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt_q <= 4'd0;
      rcnt_q <= '0;
      ocnt_q <= 3'd0;
      l_q    <= 2'b00;
    end else if (abort) begin
      wcnt_q <= 4'd0;
      rcnt_q <= '0;
      ocnt_q <= 3'd0;
    end else begin
      if (in_hs) begin
        wcnt_q <= wr_idx + 4'd1;
        if (state_q == S_IDLE) l_q <= l_i;
      end
      if (state_q == S_START)      rcnt_q <= '0;
      else if (state_q == S_ROUND) rcnt_q <= rcnt_q + RW'(1);
      if (state_q == S_CAPTURE) ocnt_q <= 3'd0;
      else if (out_hs)          ocnt_q <= ocnt_q + 3'd1;
    end
  end

  // Data buffers carry no reset; validity is tracked by the FSM alone.
  always_ff @(posedge clk_i) begin
    if (in_hs) x_q[wr_idx] <= in_data_i;
    if (state_q == S_CAPTURE) begin
      for (int k = 0; k < 8; k++) y_q[k] <= y_i[k*SLEN +: SLEN];
    end
  end

  generate
    for (genvar k = 0; k < 16; k++) begin : g_x
      assign x_o[k*SLEN +: SLEN] = x_q[k];
    end
  endgenerate

  assign out_data_o = y_q[ocnt_q];
  assign l_o        = l_q;

endmodule
`default_nettype wire

// File: tb/tb_bash_hash_ctrl.sv
`default_nettype none
// tb_bash_hash_ctrl : directed self-checking bench for bash_hash_ctrl.
module tb_bash_hash_ctrl;
  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [1:0]    l_i = 2'b00;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [63:0]   in_data_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [63:0]   out_data_o;
  logic          out_last_o, busy_o, prep_o, start_o, work_o;
  logic [1:0]    l_o;
  logic [1023:0] x_o;
  logic [511:0]  y_i = '0;
`ifdef BASH_HASH_CTRL_ABORT_EN
  logic          abort_i = 1'b0;
`endif

  int errors = 0, checks = 0, cyc = 0;
  int start_cnt = 0, prep_cnt = 0, work_cnt = 0, overlap_cnt = 0, l_bad = 0, hs_cnt = 0;
  logic [1:0]    exp_l = 2'b00;
  logic [1023:0] x_at_start = '0;

  bash_hash_ctrl #(.SLEN(64), .ROUNDS(24)) dut (
    .clk_i(clk), .rst_i(rst_i),
`ifdef BASH_HASH_CTRL_ABORT_EN
    .abort_i(abort_i),
`endif
    .l_i(l_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .busy_o(busy_o), .prep_o(prep_o), .start_o(start_o),
    .work_o(work_o), .l_o(l_o), .x_o(x_o), .y_i(y_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #2;
    if (!rst_i) begin
      if (start_o) begin start_cnt++; x_at_start = x_o; end
      if (prep_o) prep_cnt++;
      if (work_o) work_cnt++;
      if (start_o && work_o) overlap_cnt++;
      if (busy_o && l_o !== exp_l) l_bad++;
      if (in_valid_i && in_ready_o) hs_cnt++;
    end
  end

  function automatic logic [511:0] ypat(input int seed);
    logic [511:0] v;
    for (int j = 0; j < 8; j++)
      v[j*64 +: 64] = 64'hC0DE_0000_0000_0000 | (64'(seed) << 8) | 64'(j);
    return v;
  endfunction

  task automatic load_block(input logic [1:0] l, input logic [63:0] base, input bit gaps,
                            output int hs_cyc, output bit ok);
    int k = 0, guard = 0;
    hs_cyc = -1;
    while (k < 16 && guard < 200) begin
      in_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data_i  = base + 64'(k);
      l_i        = (k == 0) ? l : ~l;
      #1;
      if (in_valid_i && in_ready_o) begin k++; hs_cyc = cyc; end
      @(negedge clk);
      guard++;
    end
    in_valid_i = 1'b0;
    ok = (k == 16);
  endtask

  task automatic collect_output(input int stall_word, output int first, output int nw,
                                output logic [767:0] wordsv, output logic [11:0] lasts,
                                output bit stable, output bit ready_back);
    int guard = 0, stall = 0;
    logic [63:0] held = '0;
    nw = 0; lasts = '0; wordsv = '0; stable = 1'b1; ready_back = 1'b0; first = -1;
    out_ready_i = 1'b1;
    while (!out_valid_o && guard < 100) begin @(negedge clk); guard++; end
    if (out_valid_o) begin
      first = cyc;
      in_valid_i = 1'b0;
      y_i = {8{64'hBAD0_BAD0_BAD0_BAD0}};
      guard = 0;
      while (guard < 60) begin
        guard++;
        if (nw == stall_word && stall < 5) begin
          out_ready_i = 1'b0;
          #1;
          if (stall == 0) held = out_data_o;
          else if (out_data_o !== held || out_valid_o !== 1'b1) stable = 1'b0;
          stall++;
          @(negedge clk);
        end else begin
          out_ready_i = 1'b1;
          #1;
          if (out_valid_o !== 1'b1) break;
          if (nw < 12) begin wordsv[nw*64 +: 64] = out_data_o; lasts[nw] = out_last_o; end
          nw++;
          if (out_last_o === 1'b1) begin
            @(negedge clk);
            ready_back = (in_ready_o === 1'b1) && (out_valid_o === 1'b0);
            break;
          end
          @(negedge clk);
        end
      end
    end
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready_o); end
    checks++;
    if ({out_valid_o, out_last_o, busy_o, prep_o, start_o, work_o} !== 6'b0) begin
      errors++; $display("FAIL reset_controls: got %b want 000000",
                         {out_valid_o, out_last_o, busy_o, prep_o, start_o, work_o});
    end
    checks++; if (l_o !== 2'b00) begin errors++; $display("FAIL reset_l: got %b want 00", l_o); end
    rst_i = 1'b0;
    #1;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL release_busy: got %b want 0", busy_o); end
    @(negedge clk);
  endtask

  task automatic test_hash(input logic [1:0] l, input logic [63:0] base, input bit gaps,
                           input int stall_word, input int seed);
    int s0, p0, w0, o0, lb0, h0, hs, first, nw, nexp;
    bit ok, stable, back;
    logic [1023:0] xexp;
    logic [511:0]  yexp;
    logic [767:0]  wordsv;
    logic [11:0]   lasts, exp_last;
    @(negedge clk);
    nexp = (l == 2'b00) ? 4 : (l == 2'b01) ? 6 : 8;
    exp_last = 12'd1 << (nexp - 1);
    for (int k = 0; k < 16; k++) xexp[k*64 +: 64] = base + 64'(k);
    yexp = ypat(seed);
    y_i = yexp;
    exp_l = l;
    s0 = start_cnt; p0 = prep_cnt; w0 = work_cnt; o0 = overlap_cnt; lb0 = l_bad; h0 = hs_cnt;
    load_block(l, base, gaps, hs, ok);
    checks++; if (!ok) begin errors++; $display("FAIL load_%0d: accepted fewer than 16 words", seed); end
    if (gaps) begin in_valid_i = 1'b1; in_data_i = 64'hFFFF_EEEE_DDDD_CCCC; end
    collect_output(stall_word, first, nw, wordsv, lasts, stable, back);
    checks++; if (x_at_start !== xexp) begin errors++; $display("FAIL x_at_start_%0d: got %h want %h", seed, x_at_start[127:0], xexp[127:0]); end
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL start_cycles_%0d: got %0d want 1", seed, start_cnt - s0); end
    checks++; if (prep_cnt - p0 != 1) begin errors++; $display("FAIL prep_cycles_%0d: got %0d want 1", seed, prep_cnt - p0); end
    checks++; if (work_cnt - w0 != 23) begin errors++; $display("FAIL work_cycles_%0d: got %0d want 23", seed, work_cnt - w0); end
    checks++; if (overlap_cnt != o0) begin errors++; $display("FAIL start_work_overlap_%0d: got %0d want 0", seed, overlap_cnt - o0); end
    checks++; if (first - hs != 26) begin errors++; $display("FAIL latency_%0d: got %0d want 26", seed, first - hs); end
    checks++; if (nw != nexp) begin errors++; $display("FAIL word_count_%0d: got %0d want %0d", seed, nw, nexp); end
    for (int j = 0; j < nexp; j++) begin
      checks++;
      if (wordsv[j*64 +: 64] !== yexp[j*64 +: 64]) begin
        errors++; $display("FAIL digest_%0d_w%0d: got %h want %h", seed, j, wordsv[j*64 +: 64], yexp[j*64 +: 64]);
      end
    end
    checks++; if (lasts !== exp_last) begin errors++; $display("FAIL last_flag_%0d: got %b want %b", seed, lasts, exp_last); end
    if (stall_word >= 0) begin
      checks++; if (!stable) begin errors++; $display("FAIL stall_stable_%0d: data or valid moved during stall", seed); end
    end
    checks++; if (!back) begin errors++; $display("FAIL ready_return_%0d: got 0 want 1", seed); end
    checks++; if (l_bad != lb0) begin errors++; $display("FAIL l_stable_%0d: %0d bad cycles want 0", seed, l_bad - lb0); end
    checks++; if (hs_cnt - h0 != 16) begin errors++; $display("FAIL in_handshakes_%0d: got %0d want 16", seed, hs_cnt - h0); end
    checks++; if (x_o !== xexp) begin errors++; $display("FAIL x_hold_%0d: got %h want %h", seed, x_o[127:0], xexp[127:0]); end
  endtask

  task automatic test_reset_mid_round;
    int hs, guard = 0;
    bit ok;
    @(negedge clk);
    exp_l = 2'b10;
    load_block(2'b10, 64'h100, 1'b0, hs, ok);
    while (cyc < hs + 12 && guard < 50) begin @(negedge clk); guard++; end
    checks++; if (work_o !== 1'b1) begin errors++; $display("FAIL pre_reset_work: got %b want 1", work_o); end
    rst_i = 1'b1;
    #1;
    checks++; if (work_o !== 1'b0) begin errors++; $display("FAIL rst_work: got %b want 0", work_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready_o); end
    test_hash(2'b10, 64'h200, 1'b0, -1, 5);
  endtask

`ifdef BASH_HASH_CTRL_ABORT_EN
  task automatic test_abort;
    int k = 0, guard = 0, s0, hs;
    bit ok;
    logic [511:0] yexp;
    @(negedge clk);
    exp_l = 2'b01;
    s0 = start_cnt;
    while (k < 7 && guard < 50) begin
      in_valid_i = 1'b1; in_data_i = 64'hAB00 + 64'(k); l_i = 2'b01;
      #1;
      if (in_ready_o) k++;
      @(negedge clk);
      guard++;
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0; in_valid_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_load_busy: got %b want 0", busy_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL abort_load_ready: got %b want 1", in_ready_o); end
    repeat (30) @(negedge clk);
    checks++; if (start_cnt != s0) begin errors++; $display("FAIL abort_no_start: got %0d want 0", start_cnt - s0); end
    exp_l = 2'b11;
    yexp = ypat(8);
    y_i = yexp;
    load_block(2'b11, 64'h6000, 1'b0, hs, ok);
    guard = 0;
    while (!out_valid_o && guard < 100) begin @(negedge clk); guard++; end
    out_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready_i = 1'b0;
    checks++; if (out_data_o !== yexp[128 +: 64]) begin errors++; $display("FAIL abort_pre_word: got %h want %h", out_data_o, yexp[128 +: 64]); end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL abort_unload_valid: got %b want 0", out_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_unload_busy: got %b want 0", busy_o); end
    test_hash(2'b10, 64'h7000, 1'b0, -1, 9);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_hash(2'b10, 64'h0,    1'b0, -1, 1);
    test_hash(2'b00, 64'h1000, 1'b0, -1, 2);
    test_hash(2'b01, 64'h2000, 1'b0, -1, 3);
    test_hash(2'b11, 64'h3000, 1'b1, -1, 4);
    test_hash(2'b10, 64'h4000, 1'b0,  2, 6);
    test_reset_mid_round;
`ifdef BASH_HASH_CTRL_ABORT_EN
    test_abort;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
